// File: rtl/zb_seq_pkg.sv
// Shared types for the TOP path sequencer: FSM states, path modes and the
// select pattern each mode drives onto SEL1/SEL3/SEL15.
package zb_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_WRITE,
    ST_GAP,
    ST_READ,
    ST_DONE,
    ST_ERROR
  } state_e;

  typedef enum logic [1:0] {
    MODE_FULL   = 2'd0,
    MODE_INFIFO = 2'd1,
    MODE_WRONLY = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef struct packed {
    logic [2:0] sel1;
    logic       sel3;
    logic [2:0] sel15;
  } sel_t;

  localparam sel_t SEL_FULL   = '{sel1: 3'b000, sel3: 1'b0, sel15: 3'b000};
  localparam sel_t SEL_INFIFO = '{sel1: 3'b010, sel3: 1'b1, sel15: 3'b001};

  // Write-only mode reuses the inFIFO stand-alone routing; it only skips READ.
  function automatic sel_t mode_sel(input mode_e m);
    case (m)
      MODE_FULL: return SEL_FULL;
      default:   return SEL_INFIFO;
    endcase
  endfunction

endpackage

// File: rtl/zb_seq_watchdog.sv
// Stall watchdog for the sequencer data phases: counts consecutive cycles in
// which the active phase's enable is gated low and flags a timeout when the
// count reaches TIMEOUT_CYCLES. Used only when ZB_SEQ_TIMEOUT_EN is defined.
module zb_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_active,
  input  logic i_stall,
  input  logic i_beat,
  output logic o_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_stall_cnt;

  // Count consecutive stalls; any beat or leaving the data phase restarts it.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_active || i_beat) begin
      r_stall_cnt <= '0;
    end else if (i_stall) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Fires during the TIMEOUT_CYCLES-th consecutive stall cycle.
  assign o_timeout = i_stall && (r_stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/zb_path_sequencer.sv
// Path sequencer beside TOP: turns a start/done handshake into select setup,
// an inFIFO write burst, an idle gap, an outFIFO read burst and a done pulse.
// Optional feature macro: ZB_SEQ_TIMEOUT_EN (stall watchdog -> ERROR).
module zb_path_sequencer
  import zb_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2,
  parameter int GAP_CYCLES     = 4
`ifdef ZB_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic       inClock,
  input  logic       inReset,
  input  logic       inStart,
  input  logic [1:0] inMode,
  input  logic [3:0] inBurstLen,
  input  logic       inFifoFull,
  input  logic       inFifoEmpty,
  output logic       outWriteEnable,
  output logic       outReadEnable,
  output logic [2:0] outSEL1,
  output logic       outSEL3,
  output logic [2:0] outSEL15,
  output logic       outBusy,
  output logic       outDone,
  output logic       outError
);

  localparam int TIMER_MAX = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  state_e             r_state;
  state_e             w_next_state;
  mode_e              r_mode;
  logic [3:0]         r_len;
  logic [3:0]         r_beat;
  logic [TIMER_W-1:0] r_timer;
  sel_t               r_sel;

  logic w_start_ok;
  logic w_we;
  logic w_re;
  logic w_last_beat;
  logic w_settle_done;
  logic w_gap_done;
  logic w_timeout;

  assign w_start_ok    = (r_state == ST_IDLE) && inStart;
  assign w_we          = (r_state == ST_WRITE) && !inFifoFull;
  assign w_re          = (r_state == ST_READ) && !inFifoEmpty;
  assign w_last_beat   = (r_beat == r_len - 4'd1);
  assign w_settle_done = (r_timer == TIMER_W'(SETTLE_CYCLES - 1));
  assign w_gap_done    = (r_timer == TIMER_W'(GAP_CYCLES - 1));

`ifdef ZB_SEQ_TIMEOUT_EN
  logic w_active;
  logic w_stall;

  assign w_active = (r_state == ST_WRITE) || (r_state == ST_READ);
  assign w_stall  = w_active && !(w_we || w_re);

  zb_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk    (inClock),
    .i_rst    (inReset),
    .i_active (w_active),
    .i_stall  (w_stall),
    .i_beat   (w_we || w_re),
    .o_timeout(w_timeout)
  );
`else
  // Without the watchdog a stall simply waits for the FIFO flag to clear.
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge inClock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (inReset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path through the case leaves it unassigned
    // (which would infer a latch).
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (inStart) begin
          w_next_state = (mode_e'(inMode) == MODE_RSVD) ? ST_ERROR : ST_CONFIG;
        end
      end
      ST_CONFIG: begin
        if (w_settle_done) begin
          w_next_state = (r_len == 4'd0) ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (w_timeout) begin
          w_next_state = ST_ERROR;
        end else if (w_we && w_last_beat) begin
          w_next_state = (r_mode == MODE_WRONLY) ? ST_DONE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_gap_done) begin
          w_next_state = ST_READ;
        end
      end
      ST_READ: begin
        if (w_timeout) begin
          w_next_state = ST_ERROR;
        end else if (w_re && w_last_beat) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      ST_ERROR: begin
        // Start here only clears the error; it is not taken as a request.
        if (inStart) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Transaction registers: latched request, selects, phase timer, beat count.
  always_ff @(posedge inClock) begin
    if (inReset) begin
      r_mode  <= MODE_FULL;
      r_len   <= '0;
      r_sel   <= '0;
      r_timer <= '0;
      r_beat  <= '0;
    end else begin
      if (w_start_ok) begin
        r_mode <= mode_e'(inMode);
        r_len  <= inBurstLen;
        // Reserved mode never reaches CONFIG, so the previous routing stays.
        if (mode_e'(inMode) != MODE_RSVD) begin
          r_sel <= mode_sel(mode_e'(inMode));
        end
      end

      if (w_next_state != r_state) begin
        r_timer <= '0;
      end else if ((r_state == ST_CONFIG) || (r_state == ST_GAP)) begin
        r_timer <= r_timer + 1'b1;
      end

      // Stall cycles leave the count alone, so no beat is ever lost.
      if (w_next_state != r_state) begin
        r_beat <= '0;
      end else if (w_we || w_re) begin
        r_beat <= r_beat + 4'd1;
      end
    end
  end

  // Output decode from the current state.
  always_comb begin
    outBusy        = 1'b0;
    outDone        = 1'b0;
    outError       = 1'b0;
    outWriteEnable = w_we;
    outReadEnable  = w_re;
    case (r_state)
      ST_CONFIG, ST_WRITE, ST_GAP, ST_READ: outBusy  = 1'b1;
      ST_DONE:                              outDone  = 1'b1;
      ST_ERROR:                             outError = 1'b1;
      default:                              outBusy  = 1'b0;
    endcase
  end

  assign outSEL1  = r_sel.sel1;
  assign outSEL3  = r_sel.sel3;
  assign outSEL15 = r_sel.sel15;

endmodule

// File: tb/tb_zb_path_sequencer.sv
// Self-checking bench for zb_path_sequencer: a phase-schedule model checks all
// outputs every cycle, directed transactions pin the model with hand-computed
// counts and latencies, then a randomized stream exercises everything at once.
// Build with ZB_SEQ_TIMEOUT_EN defined to cover the watchdog variant.
module tb_zb_path_sequencer;

  localparam int SETTLE = 2;
  localparam int GAP    = 4;
`ifdef ZB_SEQ_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`endif

  logic       clk = 1'b0;
  logic       inReset = 1'b1;
  logic       inStart = 1'b0;
  logic [1:0] inMode = 2'd0;
  logic [3:0] inBurstLen = 4'd0;
  logic       inFifoFull = 1'b0;
  logic       inFifoEmpty = 1'b0;
  logic       outWriteEnable, outReadEnable, outSEL3, outBusy, outDone, outError;
  logic [2:0] outSEL1, outSEL15;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  zb_path_sequencer #(
    .SETTLE_CYCLES(SETTLE),
    .GAP_CYCLES   (GAP)
`ifdef ZB_SEQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TB_TIMEOUT)
`endif
  ) dut (
    .inClock       (clk),
    .inReset       (inReset),
    .inStart       (inStart),
    .inMode        (inMode),
    .inBurstLen    (inBurstLen),
    .inFifoFull    (inFifoFull),
    .inFifoEmpty   (inFifoEmpty),
    .outWriteEnable(outWriteEnable),
    .outReadEnable (outReadEnable),
    .outSEL1       (outSEL1),
    .outSEL3       (outSEL3),
    .outSEL15      (outSEL15),
    .outBusy       (outBusy),
    .outDone       (outDone),
    .outError      (outError)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model: a schedule of phases ----------------
  // A transaction is a list of phases; timed phases burn one entry per cycle,
  // beat phases burn one entry per enabled cycle.
  typedef enum {P_CONFIG, P_WRITE, P_GAP, P_READ, P_DONE} phase_e;
  phase_e     ph_q[$];
  int         cnt_q[$];
  bit         m_error = 1'b0;
  logic [6:0] m_sel = 7'd0;
  int         m_stall = 0;
  bit         m_en;

  function automatic logic [11:0] model_out();
    logic we, re, busy, done;
    we = 0; re = 0; busy = 0; done = 0;
    if (ph_q.size() > 0) begin
      we   = (ph_q[0] == P_WRITE) && !inFifoFull;
      re   = (ph_q[0] == P_READ) && !inFifoEmpty;
      busy = (ph_q[0] != P_DONE);
      done = (ph_q[0] == P_DONE);
    end
    return {we, re, m_sel, busy, done, m_error};
  endfunction

  task automatic model_step();
    if (inReset) begin
      ph_q.delete(); cnt_q.delete();
      m_error = 0; m_sel = 7'd0; m_stall = 0;
    end else if (m_error) begin
      if (inStart) m_error = 0;
    end else if (ph_q.size() == 0) begin
      if (inStart) begin
        if (inMode == 2'd3) begin
          m_error = 1;
        end else begin
          m_sel = (inMode == 2'd0) ? 7'b000_0_000 : 7'b010_1_001;
          ph_q.push_back(P_CONFIG); cnt_q.push_back(SETTLE);
          if (inBurstLen != 0) begin
            ph_q.push_back(P_WRITE); cnt_q.push_back(int'(inBurstLen));
            if (inMode != 2'd2) begin
              ph_q.push_back(P_GAP);  cnt_q.push_back(GAP);
              ph_q.push_back(P_READ); cnt_q.push_back(int'(inBurstLen));
            end
          end
          ph_q.push_back(P_DONE); cnt_q.push_back(1);
        end
      end
    end else begin
      if (ph_q[0] == P_WRITE || ph_q[0] == P_READ) begin
        m_en = (ph_q[0] == P_WRITE) ? !inFifoFull : !inFifoEmpty;
        if (m_en) begin
          cnt_q[0] = cnt_q[0] - 1;
          m_stall = 0;
        end else begin
          m_stall++;
`ifdef ZB_SEQ_TIMEOUT_EN
          if (m_stall == TB_TIMEOUT) begin
            ph_q.delete(); cnt_q.delete();
            m_error = 1; m_stall = 0;
          end
`endif
        end
      end else begin
        cnt_q[0] = cnt_q[0] - 1;
      end
      if (cnt_q.size() > 0 && cnt_q[0] == 0) begin
        void'(ph_q.pop_front());
        void'(cnt_q.pop_front());
      end
    end
  endtask

  // Compare on the falling edge, advance the model on the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      check("cycle_outputs",
            32'({outWriteEnable, outReadEnable, outSEL1, outSEL3, outSEL15,
                 outBusy, outDone, outError}),
            32'(model_out()));
      if (outWriteEnable && outReadEnable) check("enables_exclusive", 32'd1, 32'd0);
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_txn(input logic [1:0] mode, input logic [3:0] len,
                         input int f0, input int fn, input int e0, input int en,
                         input int budget,
                         output int we_cnt, output int re_cnt, output int done_at,
                         output logic [6:0] sel_c1);
    we_cnt = 0; re_cnt = 0; done_at = -1; sel_c1 = 7'd0;
    @(posedge clk); #2;
    inStart = 1; inMode = mode; inBurstLen = len;
    inFifoFull = 0; inFifoEmpty = 0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #2;
      // Mid-transaction request changes must be ignored.
      inStart = 0; inMode = 2'($urandom); inBurstLen = 4'($urandom);
      inFifoFull  = (k >= f0) && (k < f0 + fn);
      inFifoEmpty = (k >= e0) && (k < e0 + en);
      @(negedge clk);
      if (outWriteEnable) we_cnt++;
      if (outReadEnable) re_cnt++;
      if (k == 1) sel_c1 = {outSEL1, outSEL3, outSEL15};
      if (outDone) begin
        done_at = k;
        break;
      end
    end
    inFifoFull = 0; inFifoEmpty = 0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
    end
  endtask

  int         we_c, re_c, done_c, err_at;
  logic [6:0] sel_c;
  logic       busy_late;

  initial begin
    // Test 1: reset 5 cycles, mode 1 len 3, no stalls.
    cycles(5);
    inReset = 0;
    @(negedge clk);
    check("reset_outputs", 32'({outWriteEnable, outReadEnable, outSEL1, outSEL3,
                                outSEL15, outBusy, outDone, outError}), 32'd0);
    run_txn(2'd1, 4'd3, 0, 0, 0, 0, 40, we_c, re_c, done_c, sel_c);
    check("t1_sel", 32'(sel_c), 32'b010_1_001);
    check("t1_we_beats", 32'(we_c), 32'd3);
    check("t1_re_beats", 32'(re_c), 32'd3);
    check("t1_done_at", 32'(done_c), 32'd13);

    // Test 2: mode 1 len 4, full held 5 cycles mid-WRITE (cycles 4..8).
    run_txn(2'd1, 4'd4, 4, 5, 0, 0, 60, we_c, re_c, done_c, sel_c);
    check("t2_we_beats", 32'(we_c), 32'd4);
    check("t2_re_beats", 32'(re_c), 32'd4);
    check("t2_done_at", 32'(done_c), 32'd20);

    // Test 3: write-only mode, len 2.
    run_txn(2'd2, 4'd2, 0, 0, 0, 0, 40, we_c, re_c, done_c, sel_c);
    check("t3_we_beats", 32'(we_c), 32'd2);
    check("t3_re_beats", 32'(re_c), 32'd0);
    check("t3_done_at", 32'(done_c), 32'd5);

    // Test 4: reserved mode -> ERROR, start clears, next start runs.
    @(posedge clk); #2;
    inStart = 1; inMode = 2'd3; inBurstLen = 4'd5;
    @(posedge clk); #2;
    inStart = 0;
    @(negedge clk);
    check("t4_error_set", 32'(outError), 32'd1);
    check("t4_busy_in_error", 32'(outBusy), 32'd0);
    @(posedge clk); #2;
    inStart = 1;
    @(posedge clk); #2;
    inStart = 0;
    @(negedge clk);
    check("t4_error_cleared", 32'({outError, outBusy}), 32'd0);
    run_txn(2'd0, 4'd1, 0, 0, 0, 0, 40, we_c, re_c, done_c, sel_c);
    check("t4_third_sel", 32'(sel_c), 32'd0);
    check("t4_third_done_at", 32'(done_c), 32'd9);

    // Test 5: reset during READ, then a fresh transaction behaves as test 1.
    @(posedge clk); #2;
    inStart = 1; inMode = 2'd0; inBurstLen = 4'd3;
    cycles(1);
    inStart = 0;
    cycles(9);
    @(negedge clk);
    check("t5_in_read", 32'(outReadEnable), 32'd1);
    @(posedge clk); #2;
    inReset = 1;
    @(posedge clk); #2;
    @(negedge clk);
    check("t5_reset_outputs", 32'({outWriteEnable, outReadEnable, outSEL1, outSEL3,
                                   outSEL15, outBusy, outDone, outError}), 32'd0);
    inReset = 0;
    run_txn(2'd1, 4'd3, 0, 0, 0, 0, 40, we_c, re_c, done_c, sel_c);
    check("t5_sel", 32'(sel_c), 32'b010_1_001);
    check("t5_we_beats", 32'(we_c), 32'd3);
    check("t5_re_beats", 32'(re_c), 32'd3);
    check("t5_done_at", 32'(done_c), 32'd13);

    // Test 6: empty held high through READ.
    err_at = -1;
    busy_late = 1'b0;
    @(posedge clk); #2;
    inStart = 1; inMode = 2'd0; inBurstLen = 4'd2;
    for (int k = 1; k <= 110; k++) begin
      @(posedge clk); #2;
      inStart = 0; inFifoEmpty = 1;
      @(negedge clk);
      if (outError && err_at < 0) err_at = k;
      if (k == 109) busy_late = outBusy;
    end
`ifdef ZB_SEQ_TIMEOUT_EN
    check("t6_timeout_at", 32'(err_at), 32'd17);
`else
    check("t6_still_busy", 32'(busy_late), 32'd1);
    check("t6_no_error", 32'(err_at), 32'hFFFF_FFFF);
`endif
    @(posedge clk); #2;
    inReset = 1; inFifoEmpty = 0;
    cycles(2);
    inReset = 0;

    // Randomized stream: starts (also while busy), all modes, stalls, resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      inStart     = ($urandom_range(0, 5) == 0);
      inMode      = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      inBurstLen  = 4'($urandom);
      inFifoFull  = ($urandom_range(0, 3) == 0);
      inFifoEmpty = ($urandom_range(0, 3) == 0);
      inReset     = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #2;
    inReset = 0; inStart = 0;
    @(negedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
